mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in the E stage. Operands come from GRF read data after forwarding.
- HI/LO read values return down the pipe as MFHI/MFLO results and end up on the GRF write port in W.
- Drives `busy` so the hazard unit stalls MD-class instructions in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request qualifier for op, sampled at posedge.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- rs_val  input  32  operand A (dividend / multiplicand / MTHI/MTLO source).
- rt_val  input  32  operand B (divisor / multiplier).
- busy  output  1  high while a mult/div is in flight.
- hi  output  32  current HI register value, combinational from register.
- lo  output  32  current LO register value, combinational from register.

Behaviour:
- Reset (any cycle, including mid-operation): HI=0, LO=0, busy=0, counter=0. Any in-flight result is discarded.
- States: IDLE (busy=0) and RUN (busy=1). An internal down-counter and pending_hi/pending_lo registers hold the in-flight result.
- IDLE, start=1, op in {0,1} at edge t:
  - capture the 64-bit product into pending;
  - load counter=MULT_CYCLES, enter RUN.
- IDLE, start=1, op in {2,3} at edge t:
  - capture quotient into pending_lo and remainder into pending_hi;
  - load counter=DIV_CYCLES, enter RUN.
- RUN: the counter decrements each edge.
  - At the edge where counter goes 1→0: HI<=pending_hi, LO<=pending_lo, busy drops.
  - busy is therefore high for exactly N cycles after edge t.
  - New HI/LO is visible on hi/lo in the cycle busy first reads 0.
- MULT: signed 32x32→64. MULTU: unsigned 32x32→64. HI=product[63:32], LO=product[31:0].
- DIV (signed): quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt_val=0, DIV or DIVU): full DIV_CYCLES busy period still runs; at completion HI/LO keep their prior values.
- MTHI/MTLO (op 4/5, start=1, IDLE): HI or LO <= rs_val at the same edge; the other register is unchanged; busy stays 0.
- start while busy (any op): ignored; the in-flight result is unaffected. The hazard unit must prevent this, and the DV bench checks that it is harmless.
- start=1 with op 6/7: no state change.
- start=0: op, rs_val and rt_val are don't-care.
- Back-to-back: start accepted in the first IDLE cycle after completion. No dead cycle beyond the busy window.
- hi/lo never change except at reset, MT* write, or mult/div completion edge.

Test Plan:
- Reset then idle 3 cycles: busy=0, hi=0, lo=0. Reset pulse asserted mid-DIV (3rd busy cycle): next cycle busy=0, hi=lo=0, and no late update follows.
- MULT rs=0xFFFFFFFE (-2), rt=3: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Old values held during busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF: after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2: busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU rs=7, rt=2: lo=3, hi=1.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive edges: hi/lo update next cycle, busy stays 0.
  - Then DIVU rt=0: busy 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0 afterwards.
- Start MULT; during busy issue MTHI 0xDEADBEEF and DIV: both ignored, and the MULT result lands on schedule.
  - Start MULTU 2x3 on the first idle cycle after: busy again 5 cycles, lo=6, hi=0.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO for the E stage.
// A result is computed at issue, parked in pending_hi/lo and committed when the busy count expires.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   pending_hi;
  logic [31:0]   pending_lo;
  logic          commit;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] abs_b_nz;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] divisor_nz;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Signed divide on magnitudes; a zero divisor is swapped for 1 so the datapath
  // stays defined, and commit is cleared so the result is never written back.
  assign abs_a      = rs_val[31] ? -rs_val : rs_val;
  assign abs_b      = rt_val[31] ? -rt_val : rt_val;
  assign abs_b_nz   = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign q_mag      = abs_a / abs_b_nz;
  assign r_mag      = abs_a % abs_b_nz;
  assign sq         = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
  assign sr         = rs_val[31] ? -r_mag : r_mag;
  assign divisor_nz = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign uq         = rs_val / divisor_nz;
  assign ur         = rs_val % divisor_nz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      count      <= '0;
      commit     <= 1'b0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {pending_hi, pending_lo} <= prod_s;
                commit <= 1'b1;
                count  <= CW'(MULT_CYCLES);
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_MULTU: begin
                {pending_hi, pending_lo} <= prod_u;
                commit <= 1'b1;
                count  <= CW'(MULT_CYCLES);
                busy   <= 1'b1;
                state  <= RUN;
              end
              OP_DIV: begin
                pending_lo <= sq;
                pending_hi <= sr;
                commit     <= (rt_val != 32'd0);
                count      <= CW'(DIV_CYCLES);
                busy       <= 1'b1;
                state      <= RUN;
              end
              OP_DIVU: begin
                pending_lo <= uq;
                pending_hi <= ur;
                commit     <= (rt_val != 32'd0);
                count      <= CW'(DIV_CYCLES);
                busy       <= 1'b1;
                state      <= RUN;
              end
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (commit) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed cases plus random ops against an arithmetic model.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural effect of one accepted instruction.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [2:0] o);
    if (o <= 3'd1) return 5;
    if (o <= 3'd3) return 10;
    return 0;
  endfunction

  // Issue one op (called #1 after an edge), count busy cycles, and note whether hi/lo moved while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit held);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    n = 0; held = 1'b1;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd7; rs_val = $urandom; rt_val = $urandom;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 0; rt_val = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = 0; m_lo = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_idle%0d: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", i, busy, hi, lo);
      end
    end
  endtask

  task automatic test_mult;
    int n; bit held;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, n, held);
    model_op(3'd0, 32'hFFFFFFFE, 32'd3);
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL mult_busy: got %0d want 5", n); end
    total++;
    if (!held) begin bad++; $display("[TB] FAIL mult_hold: hi/lo changed during busy, got 0 want 1"); end
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      bad++; $display("[TB] FAIL mult_result: got %h_%h want ffffffff_fffffffa", hi, lo);
    end
  endtask

  task automatic test_multu;
    int n; bit held;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, n, held);
    model_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    total++;
    if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      bad++; $display("[TB] FAIL multu: got busy=%0d %h_%h want busy=5 fffffffe_00000001", n, hi, lo);
    end
  endtask

  task automatic test_div;
    int n; bit held;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, n, held);
    model_op(3'd2, 32'hFFFFFFF9, 32'd2);
    total++;
    if (n !== 10 || !held) begin bad++; $display("[TB] FAIL div_busy: got %0d held=%b want 10 held=1", n, held); end
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      bad++; $display("[TB] FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    run_op(3'd3, 32'd7, 32'd2, n, held);
    model_op(3'd3, 32'd7, 32'd2);
    total++;
    if (n !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
      bad++; $display("[TB] FAIL divu: got busy=%0d hi=%h lo=%h want 10 1 3", n, hi, lo);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n, held);
    model_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    total++;
    if (hi !== 32'd0 || lo !== 32'h80000000) begin
      bad++; $display("[TB] FAIL div_ovf: got hi=%h lo=%h want 0 80000000", hi, lo);
    end
  endtask

  task automatic test_mt_divzero;
    int n; bit held;
    run_op(3'd4, 32'h12345678, 32'd0, n, held);
    model_op(3'd4, 32'h12345678, 32'd0);
    total++;
    if (n !== 0 || hi !== 32'h12345678) begin
      bad++; $display("[TB] FAIL mthi: got busy=%0d hi=%h want 0 12345678", n, hi);
    end
    run_op(3'd5, 32'h9ABCDEF0, 32'd0, n, held);
    model_op(3'd5, 32'h9ABCDEF0, 32'd0);
    total++;
    if (n !== 0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      bad++; $display("[TB] FAIL mtlo: got busy=%0d hi=%h lo=%h want 0 12345678 9abcdef0", n, hi, lo);
    end
    run_op(3'd3, 32'd55, 32'd0, n, held);
    model_op(3'd3, 32'd55, 32'd0);
    total++;
    if (n !== 10 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      bad++; $display("[TB] FAIL divzero: got busy=%0d hi=%h lo=%h want 10 12345678 9abcdef0", n, hi, lo);
    end
  endtask

  task automatic test_ignore_busy;
    int n;
    n = 0;
    start = 1'b1; op = 3'd0; rs_val = 32'd1000; rt_val = 32'hFFFFFFF0;
    @(posedge clk); #1;
    if (busy === 1'b1) n++;
    op = 3'd4; rs_val = 32'hDEADBEEF;
    @(posedge clk); #1;
    if (busy === 1'b1) n++;
    op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    if (busy === 1'b1) n++;
    start = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      if (busy === 1'b1) n++;
    end
    model_op(3'd0, 32'd1000, 32'hFFFFFFF0);
    total++;
    if (n !== 5 || hi !== m_hi || lo !== m_lo) begin
      bad++; $display("[TB] FAIL ignore_busy: got busy=%0d %h_%h want 5 %h_%h", n, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit held;
    run_op(3'd1, 32'd2, 32'd3, n, held);
    model_op(3'd1, 32'd2, 32'd3);
    total++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'd6) begin
      bad++; $display("[TB] FAIL back_to_back: got busy=%0d hi=%h lo=%h want 5 0 6", n, hi, lo);
    end
  endtask

  task automatic test_random;
    int n; bit held;
    logic [2:0] o; logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(o, a, b, n, held);
      model_op(o, a, b);
      total++;
      if (n !== exp_cycles(o) || !held || hi !== m_hi || lo !== m_lo) begin
        bad++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got busy=%0d held=%b %h_%h want %0d 1 %h_%h",
                 i, o, a, b, n, held, hi, lo, exp_cycles(o), m_hi, m_lo);
      end
    end
  endtask

  task automatic test_reset_mid_div;
    int n; bit held, quiet;
    run_op(3'd4, 32'h00000055, 32'd0, n, held);
    start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_mid_div: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin bad++; $display("[TB] FAIL reset_no_late_update: got 0 want 1"); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_mt_divzero;
    test_ignore_busy;
    test_back_to_back;
    test_random;
    test_reset_mid_div;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
